pipe_fetch_unit: RTL and testbench

- Instruction fetch stage of the pipelined RV32I core; supplies instructions to the decode/control stage and consumes its PC_SEL/target redirect.
- Issues in-order word requests to instruction memory with a valid/ready handshake and accepts in-order responses.
- Buffers responses in a small FIFO tagged with their PC, and discards stale in-flight responses after a redirect.

---
 rtl/pipe_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pipe_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_unit.sv
// Fetch stage: issues in-order imem word requests and buffers PC-tagged responses for decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/discarded counters.
module pipe_fetch_unit #(
   parameter int unsigned        X_LEN      = 32,
   parameter logic [X_LEN-1:0]   RESET_PC   = '0,
   parameter int unsigned        FIFO_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             imem_req_valid_o,
   input  logic             imem_req_ready_i,
   output logic [X_LEN-1:0] imem_addr_o,
   input  logic             imem_rsp_valid_i,
   input  logic [X_LEN-1:0] imem_rsp_data_i,
   input  logic             pc_sel_i,
   input  logic [X_LEN-1:0] target_i,
   output logic             instr_valid_o,
   input  logic             instr_ready_i,
   output logic [X_LEN-1:0] instr_o,
   output logic [X_LEN-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      perf_fetched_o,
   output logic [31:0]      perf_discarded_o
`endif
);
   localparam int unsigned      PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned      CW   = PW + 1;
   localparam logic [X_LEN-1:0] NOP  = X_LEN'(32'h0000_0013);
   localparam logic [X_LEN-1:0] STEP = X_LEN'(4);

   logic [X_LEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, last_pc_q;
   logic [CW-1:0]    outstanding_q, outstanding_d, discard_q, discard_d, count_q, count_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [X_LEN-1:0] fifo_pc_q  [FIFO_DEPTH];
   logic [X_LEN-1:0] fifo_dat_q [FIFO_DEPTH];
   logic             req_acc, rsp_drop, push, pop, empty;
   logic [X_LEN-1:0] redirect_pc;
   logic [CW:0]      in_flight;
   logic [1:0]       unused_tgt_bits;

   assign redirect_pc     = {target_i[X_LEN-1:2], 2'b00};
   assign unused_tgt_bits = target_i[1:0];
   // Credits cover both in-flight requests and buffered entries, so the FIFO never overflows.
   assign in_flight        = {1'b0, outstanding_q} + {1'b0, count_q};
   assign empty            = (count_q == '0);
   assign imem_req_valid_o = !rst_i && !pc_sel_i && (in_flight < (CW+1)'(FIFO_DEPTH));
   assign imem_addr_o      = fetch_pc_q;
   assign req_acc          = imem_req_valid_o && imem_req_ready_i;
   assign rsp_drop         = imem_rsp_valid_i && (pc_sel_i || (discard_q != '0));
   assign push             = imem_rsp_valid_i && !rsp_drop;
   assign pop              = !empty && instr_ready_i && !pc_sel_i;
   assign instr_valid_o    = !empty;
   assign instr_o          = empty ? NOP : fifo_dat_q[rd_ptr_q];
   assign instr_pc_o       = empty ? last_pc_q : fifo_pc_q[rd_ptr_q];

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + CW'(req_acc) - CW'(imem_rsp_valid_i);
      discard_d     = discard_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (pc_sel_i) begin
         // Everything still in flight belongs to the old path and must be dropped on return.
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         discard_d  = outstanding_q - CW'(imem_rsp_valid_i);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (req_acc)  fetch_pc_d = fetch_pc_q + STEP;
         if (rsp_drop) discard_d  = discard_q - CW'(1);
         if (push) begin
            rsp_pc_d = rsp_pc_q + STEP;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         last_pc_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         last_pc_q     <= instr_pc_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]  <= rsp_pc_q;
         fifo_dat_q[wr_ptr_q] <= imem_rsp_data_i;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_discarded_q;
   logic [32:0] fetched_sum, discarded_sum;
   logic [CW:0] discard_inc;

   // Flushed entries and dropped responses can both land in one redirect cycle.
   assign discard_inc   = {1'b0, (pc_sel_i ? count_q : '0)} + (CW+1)'(rsp_drop);
   assign fetched_sum   = {1'b0, perf_fetched_q} + 33'(pop);
   assign discarded_sum = {1'b0, perf_discarded_q} + 33'(discard_inc);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_fetched_q   <= '0;
         perf_discarded_q <= '0;
      end else begin
         perf_fetched_q   <= fetched_sum[32]   ? '1 : fetched_sum[31:0];
         perf_discarded_q <= discarded_sum[32] ? '1 : discarded_sum[31:0];
      end
   end

   assign perf_fetched_o   = perf_fetched_q;
   assign perf_discarded_o = perf_discarded_q;
`endif
endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Directed bench for pipe_fetch_unit: cycle table for streaming fetch, hand sequences for
// stall, redirects, imem backpressure/latency and asynchronous reset.
module tb_pipe_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i = 1'b1;
   logic [31:0] imem_addr_o;
   logic        imem_rsp_valid_i = 1'b0;
   logic [31:0] imem_rsp_data_i = '0;
   logic        pc_sel_i = 1'b0;
   logic [31:0] target_i = '0;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b1;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o, perf_discarded_o;
`endif

   pipe_fetch_unit #(.X_LEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
      .imem_addr_o(imem_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i(imem_rsp_data_i), .pc_sel_i(pc_sel_i), .target_i(target_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .instr_pc_o(instr_pc_o)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched_o(perf_fetched_o), .perf_discarded_o(perf_discarded_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 + a;
   endfunction

   // Instruction memory: in-order, fixed latency per accept, ready optionally toggling.
   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t       q[$];
   int          cyc = 0;
   int          lat = 1;
   bit          rdy_toggle = 1'b0;
   int          n_acc = 0;
   bit          acc_s = 1'b0;
   bit          rsp_s = 1'b0;
   logic [31:0] acc_a = '0;

   always @(negedge clk_i) begin
      acc_s = !rst_i && imem_req_valid_o && imem_req_ready_i;
      acc_a = imem_addr_o;
      rsp_s = !rst_i && imem_rsp_valid_i;
   end

   always @(posedge clk_i) begin
      cyc++;
      if (rst_i) q.delete();
      else begin
         if (rsp_s && q.size() > 0) void'(q.pop_front());
         if (acc_s) begin
            q.push_back('{addr: acc_a, due: cyc + lat - 1});
            n_acc++;
         end
      end
      #1;
      imem_req_ready_i = (rdy_toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      if (!rst_i && q.size() > 0 && q[0].due <= cyc) begin
         imem_rsp_valid_i = 1'b1;
         imem_rsp_data_i  = mem_word(q[0].addr);
      end else begin
         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = '0;
      end
   end

   // Delivery scoreboard: expected PC follows reset and redirects.
   logic [31:0] exp_pc = '0;
   logic [31:0] first_pc = '1;
   int          deliv = 0;
   bit          nop_chk = 1'b0;

   always @(negedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         exp_pc   = 32'h0;
         deliv    = 0;
         first_pc = '1;
      end else begin
         if (nop_chk && !instr_valid_o) check("nop when empty", instr_o, NOP);
         if (pc_sel_i) exp_pc = {target_i[31:2], 2'b00};
         else if (instr_valid_o && instr_ready_i) begin
            check("deliver pc", instr_pc_o, exp_pc);
            check("deliver data", instr_o, mem_word(exp_pc));
            if (deliv == 0) first_pc = instr_pc_o;
            deliv++;
            exp_pc += 32'd4;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset(input int l);
      rst_i    = 1'b1;
      pc_sel_i = 1'b0;
      target_i = '0;
      lat        = l;
      rdy_toggle = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   typedef struct {
      logic        rdy;
      logic        req_vld;
      logic [31:0] addr;
      logic        ivld;
      logic [31:0] ipc;
      logic [31:0] instr;
   } vec_t;
   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0;
      int w;
      vecs[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, NOP};
      vecs[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0, NOP};
      vecs[2] = '{1'b1, 1'b0, 32'h08, 1'b1, 32'h0, mem_word(32'h0)};
      vecs[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, mem_word(32'h4)};
      vecs[4] = '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h4, NOP};
      vecs[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h8, mem_word(32'h8)};
      vecs[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC, mem_word(32'hC)};
      vecs[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'hC, NOP};

      // Reset state
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("rst req_vld", 32'(imem_req_valid_o), 32'd0);
      check("rst instr_vld", 32'(instr_valid_o), 32'd0);
      check("rst instr", instr_o, NOP);
      check("rst instr_pc", instr_pc_o, 32'h0);

      // Streaming fetch, cycle by cycle
      do_reset(1);
      for (int i = 0; i < 8; i++) begin
         instr_ready_i = vecs[i].rdy;
         @(negedge clk_i);
         check($sformatf("t1[%0d] req_vld", i), 32'(imem_req_valid_o), 32'(vecs[i].req_vld));
         check($sformatf("t1[%0d] addr", i), imem_addr_o, vecs[i].addr);
         check($sformatf("t1[%0d] instr_vld", i), 32'(instr_valid_o), 32'(vecs[i].ivld));
         check($sformatf("t1[%0d] instr_pc", i), instr_pc_o, vecs[i].ipc);
         check($sformatf("t1[%0d] instr", i), instr_o, vecs[i].instr);
         tick();
      end

      // Decode stall: credits run out after FIFO_DEPTH requests
      instr_ready_i = 1'b0;
      do_reset(1);
      base = n_acc;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         if (k >= 2) begin
            check($sformatf("t2[%0d] instr held", k), instr_o, mem_word(32'h0));
            check($sformatf("t2[%0d] instr_vld", k), 32'(instr_valid_o), 32'd1);
         end
         if (k == 4) check("t2 req_vld after credits", 32'(imem_req_valid_o), 32'd0);
         tick();
      end
      check("t2 accepts during stall", 32'(n_acc - base), 32'd2);
      instr_ready_i = 1'b1;
      repeat (20) tick();
      check("t2 resumed delivery", 32'(deliv >= 5), 32'd1);

      // Redirect with two requests in flight
      do_reset(3);
      tick();
      tick();
      pc_sel_i = 1'b1;
      target_i = 32'h103;
      @(negedge clk_i);
      check("t3 req_vld in redirect", 32'(imem_req_valid_o), 32'd0);
      tick();
      pc_sel_i = 1'b0;
      @(negedge clk_i);
      check("t3 addr after redirect", imem_addr_o, 32'h100);
      repeat (20) tick();
      check("t3 first pc", first_pc, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      check("t3 perf_discarded", perf_discarded_o, 32'd2);
      check("t3 perf_fetched", perf_fetched_o, 32'(deliv));
`endif

      // Redirect coinciding with a response, then a second redirect
      do_reset(1);
      tick();
      pc_sel_i = 1'b1;
      target_i = 32'h80;
      @(negedge clk_i);
      check("t4 req_vld in redirect", 32'(imem_req_valid_o), 32'd0);
      tick();
      target_i = 32'h200;
      @(negedge clk_i);
      check("t4 no stale instr", 32'(instr_valid_o), 32'd0);
      tick();
      pc_sel_i = 1'b0;
      @(negedge clk_i);
      check("t4 addr", imem_addr_o, 32'h200);
      check("t4 req_vld", 32'(imem_req_valid_o), 32'd1);
      repeat (15) tick();
      check("t4 first pc", first_pc, 32'h200);

      // imem backpressure and longer latency
      rdy_toggle = 1'b1;
      lat        = 3;
      nop_chk    = 1'b1;
      d0 = deliv;
      repeat (40) tick();
      check("t5 progress", 32'((deliv - d0) >= 4), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      check("t5 perf_fetched", perf_fetched_o, 32'(deliv));
      check("t5 perf_discarded", perf_discarded_o, 32'd1);
`endif
      nop_chk    = 1'b0;
      rdy_toggle = 1'b0;
      lat        = 1;

      // Asynchronous reset between edges
      w = 0;
      do begin
         @(negedge clk_i);
         w++;
      end while (!instr_valid_o && w < 30);
      check("t6 valid before reset", 32'(instr_valid_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check("t6 instr_vld in reset", 32'(instr_valid_o), 32'd0);
      check("t6 req_vld in reset", 32'(imem_req_valid_o), 32'd0);
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("t6 restart addr", imem_addr_o, 32'h0);
      check("t6 restart req_vld", 32'(imem_req_valid_o), 32'd1);
      repeat (12) tick();
      check("t6 first pc", first_pc, 32'h0);
      check("t6 delivery", 32'(deliv >= 2), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
